// File: rtl/demux_stream.sv
// Registered 1-to-NCH stream demultiplexer with per-channel valid/ready holding registers,
// explicit-select or round-robin routing. Optional per-channel accept counters: DEMUX_STREAM_CNT_EN.
module demux_stream #(
   parameter int WIDTH = 8,
   parameter int NCH   = 8,
   parameter int SELW  = $clog2(NCH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   mode,
   input  logic [SELW-1:0]        sel,
   input  logic [WIDTH-1:0]       in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [NCH*WIDTH-1:0]   out_data,
   output logic [NCH-1:0]         out_valid,
   input  logic [NCH-1:0]         out_ready,
`ifdef DEMUX_STREAM_CNT_EN
   input  logic [SELW-1:0]        cnt_sel,
   output logic [15:0]            cnt_out,
`endif
   output logic [NCH-1:0]         chan_hot,
   output logic [SELW-1:0]        seq_ptr
);

   localparam logic [SELW:0]   NCH_W = (SELW+1)'(NCH);
   localparam logic [SELW-1:0] LAST  = SELW'(NCH-1);

   logic [NCH*WIDTH-1:0] r_out_data;
   logic [NCH-1:0]       r_out_valid;
   logic [NCH-1:0]       r_chan_hot;
   logic [SELW-1:0]      r_seq_ptr;

   logic [SELW-1:0]      w_tgt;
   logic                 w_tgt_ok;
   logic [NCH-1:0]       w_tgt_dec;
   logic                 w_busy;
   logic                 w_accept;

   assign w_tgt    = mode ? r_seq_ptr : sel;
   // The round-robin pointer never leaves 0..NCH-1, so only an explicit select can be out of range.
   assign w_tgt_ok = mode | ({1'b0, sel} < NCH_W);

   // Decode the target channel without indexing past NCH (keeps X out of non-power-of-2 builds).
   always_comb begin
      w_tgt_dec = '0;
      for (int k = 0; k < NCH; k++) begin
         w_tgt_dec[k] = w_tgt_ok & (w_tgt == SELW'(k));
      end
   end

   assign w_busy   = |(w_tgt_dec & r_out_valid & ~out_ready);
   assign in_ready = rst_n & w_tgt_ok & ~w_busy;
   assign w_accept = in_valid & in_ready;

   // Channel holding registers, last-channel one-hot and round-robin pointer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_data  <= '0;
         r_out_valid <= '0;
         r_chan_hot  <= '0;
         r_seq_ptr   <= '0;
      end else begin
         for (int k = 0; k < NCH; k++) begin
            if (w_accept && w_tgt_dec[k]) begin
               r_out_data[k*WIDTH +: WIDTH] <= in_data;
               r_out_valid[k]               <= 1'b1;
            end else if (out_ready[k]) begin
               r_out_valid[k] <= 1'b0;
            end else begin
               r_out_valid[k] <= r_out_valid[k];
            end
         end
         if (w_accept) begin
            r_chan_hot <= w_tgt_dec;
         end else begin
            r_chan_hot <= r_chan_hot;
         end
         if (w_accept && mode) begin
            r_seq_ptr <= (r_seq_ptr == LAST) ? '0 : r_seq_ptr + SELW'(1);
         end else begin
            r_seq_ptr <= r_seq_ptr;
         end
      end
   end

   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign chan_hot  = r_chan_hot;
   assign seq_ptr   = r_seq_ptr;

`ifdef DEMUX_STREAM_CNT_EN
   logic [15:0] r_cnt [NCH];

   // Saturating count of words accepted per channel.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < NCH; k++) r_cnt[k] <= 16'h0000;
      end else begin
         for (int k = 0; k < NCH; k++) begin
            if (w_accept && w_tgt_dec[k] && (r_cnt[k] != 16'hFFFF)) begin
               r_cnt[k] <= r_cnt[k] + 16'h0001;
            end else begin
               r_cnt[k] <= r_cnt[k];
            end
         end
      end
   end

   // Counter read mux; an out-of-range cnt_sel matches no channel and reads 0.
   always_comb begin
      cnt_out = 16'h0000;
      for (int k = 0; k < NCH; k++) begin
         cnt_out = cnt_out | (r_cnt[k] & {16{cnt_sel == SELW'(k)}});
      end
   end
`endif

endmodule

// File: tb/tb_demux_stream.sv
// Directed, table-driven bench for demux_stream (NCH=8, WIDTH=8); counter checks when DEMUX_STREAM_CNT_EN is set.
module tb_demux_stream;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mode;
   logic [2:0]  sel;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] out_data;
   logic [7:0]  out_valid;
   logic [7:0]  out_ready;
   logic [7:0]  chan_hot;
   logic [2:0]  seq_ptr;
`ifdef DEMUX_STREAM_CNT_EN
   logic [2:0]  cnt_sel;
   logic [15:0] cnt_out;
`endif

   int checks = 0;
   int errors = 0;

   demux_stream #(.WIDTH(8), .NCH(8)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
`ifdef DEMUX_STREAM_CNT_EN
      .cnt_sel(cnt_sel), .cnt_out(cnt_out),
`endif
      .chan_hot(chan_hot), .seq_ptr(seq_ptr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       mode;
      logic [2:0] sel;
      logic [7:0] din;
      logic       vld;
      logic [7:0] rdy;
      logic       e_rdy;
      logic [7:0] e_ov;
      logic [7:0] e_hot;
      logic [2:0] e_ptr;
      int         ch;
      logic [7:0] e_d;
   } vec_t;

   vec_t tbl [18];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called just after a falling edge: drive, check in_ready, clock once, check registered outputs.
   task automatic step(input vec_t v);
      mode      = v.mode;
      sel       = v.sel;
      in_data   = v.din;
      in_valid  = v.vld;
      out_ready = v.rdy;
      #1;
      chk("in_ready", {63'd0, in_ready}, {63'd0, v.e_rdy});
      @(posedge clk);
      @(negedge clk);
      chk("out_valid", {56'd0, out_valid}, {56'd0, v.e_ov});
      chk("chan_hot", {56'd0, chan_hot}, {56'd0, v.e_hot});
      chk("seq_ptr", {61'd0, seq_ptr}, {61'd0, v.e_ptr});
      chk("out_data", {56'd0, out_data[v.ch*8 +: 8]}, {56'd0, v.e_d});
   endtask

   function automatic vec_t mk(input logic m, input logic [2:0] s, input logic [7:0] d, input logic vl,
                               input logic [7:0] r, input logic er, input logic [7:0] eov,
                               input logic [7:0] eh, input logic [2:0] ep, input int c, input logic [7:0] ed);
      vec_t v;
      v.mode = m; v.sel = s; v.din = d; v.vld = vl; v.rdy = r; v.e_rdy = er;
      v.e_ov = eov; v.e_hot = eh; v.e_ptr = ep; v.ch = c; v.e_d = ed;
      return v;
   endfunction

   initial begin
      // One-hot sweep, explicit select, everything drains each cycle.
      for (int i = 0; i < 8; i++) begin
         tbl[i] = mk(1'b0, 3'(i), 8'hA0 + 8'(i), 1'b1, 8'hFF, 1'b1,
                     8'(1 << i), 8'(1 << i), 3'd0, i, 8'hA0 + 8'(i));
      end
      // Round-robin with wrap: 10 words, pointer ends at 2.
      for (int i = 0; i < 10; i++) begin
         tbl[8 + i] = mk(1'b1, 3'd0, 8'(i), 1'b1, 8'hFF, 1'b1,
                         8'(1 << (i % 8)), 8'(1 << (i % 8)), 3'((i + 1) % 8), i % 8, 8'(i));
      end

      rst_n = 1'b0; mode = 1'b0; sel = 3'd0; in_data = 8'h00; in_valid = 1'b0; out_ready = 8'hFF;
`ifdef DEMUX_STREAM_CNT_EN
      cnt_sel = 3'd0;
`endif
      @(negedge clk);
      in_valid = 1'b1;
      #1;
      chk("rst in_ready", {63'd0, in_ready}, 64'd0);
      @(negedge clk);
      chk("rst out_valid", {56'd0, out_valid}, 64'd0);
      chk("rst chan_hot", {56'd0, chan_hot}, 64'd0);
      chk("rst seq_ptr", {61'd0, seq_ptr}, 64'd0);
      chk("rst out_data", out_data, 64'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 18; i++) step(tbl[i]);

      // Round-robin stall: fill channel 2 in mode 0, then the pointer (at 2) must wait for it.
      step(mk(1'b0, 3'd2, 8'h55, 1'b1, 8'hFB, 1'b1, 8'h04, 8'h04, 3'd2, 2, 8'h55));
      step(mk(1'b1, 3'd0, 8'h66, 1'b1, 8'hFB, 1'b0, 8'h04, 8'h04, 3'd2, 2, 8'h55));
      step(mk(1'b1, 3'd0, 8'h66, 1'b1, 8'hFB, 1'b0, 8'h04, 8'h04, 3'd2, 2, 8'h55));
      step(mk(1'b1, 3'd0, 8'h66, 1'b1, 8'hFF, 1'b1, 8'h04, 8'h04, 3'd3, 2, 8'h66));

      // Backpressure on channel 3 with channel 4 still accepted; then drain and refill in one cycle.
      step(mk(1'b0, 3'd3, 8'h11, 1'b1, 8'hF7, 1'b1, 8'h08, 8'h08, 3'd3, 3, 8'h11));
      step(mk(1'b0, 3'd3, 8'h22, 1'b1, 8'hF7, 1'b0, 8'h08, 8'h08, 3'd3, 3, 8'h11));
      step(mk(1'b0, 3'd4, 8'h33, 1'b1, 8'hF7, 1'b1, 8'h18, 8'h10, 3'd3, 4, 8'h33));
      chk("held ch3", {56'd0, out_data[3*8 +: 8]}, 64'h11);
      step(mk(1'b0, 3'd3, 8'h22, 1'b1, 8'hFF, 1'b1, 8'h08, 8'h08, 3'd3, 3, 8'h22));
      step(mk(1'b0, 3'd0, 8'h00, 1'b0, 8'hFF, 1'b1, 8'h00, 8'h08, 3'd3, 3, 8'h22));

      // Reset mid-operation with channels 1 and 5 held.
      step(mk(1'b0, 3'd1, 8'h71, 1'b1, 8'hDD, 1'b1, 8'h02, 8'h02, 3'd3, 1, 8'h71));
      step(mk(1'b0, 3'd5, 8'h75, 1'b1, 8'hDD, 1'b1, 8'h22, 8'h20, 3'd3, 5, 8'h75));
      rst_n = 1'b0; sel = 3'd0; in_valid = 1'b1;
      #1;
      chk("midrst in_ready", {63'd0, in_ready}, 64'd0);
      @(posedge clk);
      @(negedge clk);
      chk("midrst out_valid", {56'd0, out_valid}, 64'd0);
      chk("midrst chan_hot", {56'd0, chan_hot}, 64'd0);
      chk("midrst seq_ptr", {61'd0, seq_ptr}, 64'd0);
      rst_n = 1'b1;

`ifdef DEMUX_STREAM_CNT_EN
      for (int i = 0; i < 5; i++) begin
         step(mk(1'b0, 3'd6, 8'(8'hC0 + i), 1'b1, 8'hFF, 1'b1, 8'h40, 8'h40, 3'd0, 6, 8'(8'hC0 + i)));
      end
      cnt_sel = 3'd6;
      #1;
      chk("cnt ch6", {48'd0, cnt_out}, 64'd5);
      cnt_sel = 3'd0;
      #1;
      chk("cnt ch0", {48'd0, cnt_out}, 64'd0);
      cnt_sel = 3'd6;
      rst_n = 1'b0; in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("cnt after rst", {48'd0, cnt_out}, 64'd0);
`endif

      // First word after reset goes round-robin to channel 0.
      step(mk(1'b1, 3'd0, 8'h99, 1'b1, 8'hFF, 1'b1, 8'h01, 8'h01, 3'd1, 0, 8'h99));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
